// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-issue stage feeding the ALU input registers. Captures decoded ops,
//   selects the immediate for operand B, applies writeback forwarding at capture
//   time and keeps held ops fresh against later writebacks. A two-entry skid
//   buffer (main + skid) gives 1 op/clk throughput with a registered in_ready.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous discard of held and incoming ops
//   in_valid/in_ready decode-side handshake (in_ready = !skid_valid)
//   in_opcode         ALU opcode, passed through
//   in_rs_a/in_rs_b   source register indices (0 is never forwarded)
//   in_data_a/b       register-file values
//   in_imm/in_use_imm immediate and B-select
//   in_rd             destination index, passed through
//   wb_valid/rd/data  writeback bus used for forwarding
//   out_valid/ready   ALU-side handshake
//   out_a/out_b       ALU operands
//   out_opcode/out_rd opcode and destination toward the ALU
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_AW-1:0] in_rs_a,
  input  logic [REG_AW-1:0] in_rs_b,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_AW-1:0] out_rd
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OPC_W-1:0]  opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rs_b;
    logic              use_imm;
  } entry_t;

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;

  entry_t w_cap;
  entry_t w_main_refr;
  entry_t w_skid_refr;
  logic   w_in_fire;
  logic   w_out_fire;

  function automatic logic wb_hit(input logic [REG_AW-1:0] rs,
                                  input logic              v,
                                  input logic [REG_AW-1:0] rd);
    return v && (rd != '0) && (rd == rs);
  endfunction

  // Held entries pick up any writeback to their sources so a stalled op never
  // presents a stale operand; B is exempt when it carries the immediate.
  function automatic entry_t refresh(input entry_t            e,
                                     input logic              v,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [DATA_W-1:0] d);
    entry_t r;
    r = e;
    if (wb_hit(e.rs_a, v, rd)) r.a = d;
    if (!e.use_imm && wb_hit(e.rs_b, v, rd)) r.b = d;
    return r;
  endfunction

  assign in_ready   = ~r_skid_valid;
  assign w_in_fire  = in_valid & ~r_skid_valid;
  assign w_out_fire = r_main_valid & out_ready;

  always_comb begin
    w_cap         = '0;
    w_cap.opc     = in_opcode;
    w_cap.rd      = in_rd;
    w_cap.rs_a    = in_rs_a;
    w_cap.rs_b    = in_rs_b;
    w_cap.use_imm = in_use_imm;
    w_cap.a       = wb_hit(in_rs_a, wb_valid, wb_rd) ? wb_data : in_data_a;
    if (in_use_imm)
      w_cap.b = in_imm;
    else
      w_cap.b = wb_hit(in_rs_b, wb_valid, wb_rd) ? wb_data : in_data_b;
    w_main_refr = refresh(r_main, wb_valid, wb_rd, wb_data);
    w_skid_refr = refresh(r_skid, wb_valid, wb_rd, wb_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      // Main slot: refill when empty or leaving, oldest source first.
      if (!r_main_valid || w_out_fire) begin
        if (r_skid_valid) begin
          r_main       <= w_skid_refr;
          r_main_valid <= 1'b1;
        end else if (w_in_fire) begin
          r_main       <= w_cap;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else begin
        r_main <= w_main_refr;
      end
      // Skid slot: only filled when main is held; in_ready is low while it is full.
      if (r_skid_valid) begin
        if (w_out_fire)
          r_skid_valid <= 1'b0;
        else
          r_skid <= w_skid_refr;
      end else if (w_in_fire && r_main_valid && !w_out_fire) begin
        r_skid       <= w_cap;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid  = r_main_valid;
  assign out_a      = r_main.a;
  assign out_b      = r_main.b;
  assign out_opcode = r_main.opc;
  assign out_rd     = r_main.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [4:0]  in_rs_a, in_rs_b, in_rd;
  logic [31:0] in_data_a, in_data_b, in_imm;
  logic        in_use_imm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_opcode;
  logic [4:0]  out_rd;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_stage #(.DATA_W(32), .REG_AW(5), .OPC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_data_a(in_data_a),
    .in_data_b(in_data_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_opcode(out_opcode), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  // Reference model: the stage is an in-order queue of at most two pending ops,
  // each holding its current operand values.
  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  opc;
    logic [4:0]  rd, rs_a, rs_b;
    logic        use_imm;
  } op_t;

  op_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] rs);
    return wb_valid && wb_rd != 0 && wb_rd == rs;
  endfunction

  // Monitor / scoreboard: compare DUT state with the model, then advance the
  // model over the upcoming rising edge using the (now stable) inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_opcode", out_opcode, 0);
      chk("rst_out_rd", out_rd, 0);
    end else begin
      bit   ofire, ifire;
      op_t  n;
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0 && out_valid) begin
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_opcode", out_opcode, q[0].opc);
        chk("out_rd", out_rd, q[0].rd);
      end
      ofire = (q.size() > 0) && out_ready;
      ifire = in_valid && (q.size() < 2);
      if (ofire) void'(q.pop_front());
      foreach (q[i]) begin
        if (hit(q[i].rs_a)) q[i].a = wb_data;
        if (!q[i].use_imm && hit(q[i].rs_b)) q[i].b = wb_data;
      end
      if (flush) q.delete();
      else if (ifire) begin
        n.opc = in_opcode; n.rd = in_rd; n.rs_a = in_rs_a; n.rs_b = in_rs_b;
        n.use_imm = in_use_imm;
        n.a = hit(in_rs_a) ? wb_data : in_data_a;
        n.b = in_use_imm ? in_imm : (hit(in_rs_b) ? wb_data : in_data_b);
        q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic set_op(input logic [3:0] opc, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] imm, input logic ui, input logic [4:0] rd);
    in_opcode = opc; in_rs_a = ra; in_rs_b = rb; in_data_a = da; in_data_b = db;
    in_imm = imm; in_use_imm = ui; in_rd = rd; in_valid = 1;
  endtask

  // Hold the op presented until accepted, bounded.
  task automatic send(input logic [3:0] opc, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [31:0] da, input logic [31:0] db,
                      input logic [31:0] imm, input logic ui, input logic [4:0] rd);
    logic acc;
    acc = 0;
    set_op(opc, ra, rb, da, db, imm, ui, rd);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    chk("send_accept", acc, 1);
    in_valid = 0;
  endtask

  initial begin
    rst_n = 0; out_ready = 0; idle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Streaming: 8 back-to-back ops, opcode 0110 mixed in.
    out_ready = 1;
    for (int i = 0; i < 8; i++)
      send((i % 2) ? 4'b0110 : 4'(i), 5'(i + 1), 5'(i + 9), 32'h100 + i, 32'h200 + i, 0, 0, 5'(i));
    repeat (2) tick();

    // Backpressure: two accepted, third waits until the ALU drains.
    out_ready = 0;
    send(4'h1, 1, 2, 32'hA1, 32'hB1, 0, 0, 1);
    send(4'h2, 1, 2, 32'hA2, 32'hB2, 0, 0, 2);
    set_op(4'h3, 1, 2, 32'hA3, 32'hB3, 0, 0, 3);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_a", out_a, 32'hA1);
    tick();
    out_ready = 1;
    send(4'h3, 1, 2, 32'hA3, 32'hB3, 0, 0, 3);
    repeat (3) tick();

    // Forwarding at capture time.
    wb_valid = 1; wb_rd = 5; wb_data = 32'hAB;
    send(4'h4, 5, 6, 32'h11, 32'h66, 0, 0, 4);
    wb_valid = 0;
    @(negedge clk);
    chk("fwd_a", out_a, 32'hAB);
    chk("fwd_b_nomatch", out_b, 32'h66);
    tick();
    wb_valid = 1; wb_rd = 0; wb_data = 32'h99;
    send(4'h5, 0, 0, 32'h22, 32'h33, 0, 0, 5);
    wb_valid = 0;
    @(negedge clk);
    chk("fwd_r0_a", out_a, 32'h22);
    chk("fwd_r0_b", out_b, 32'h33);
    tick();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h55;
    send(4'h6, 1, 3, 32'h7, 32'h8, 32'hFFFF_FFF0, 1, 6);
    wb_valid = 0;
    @(negedge clk);
    chk("imm_b", out_b, 32'hFFFF_FFF0);
    tick();

    // Stall refresh.
    out_ready = 0;
    send(4'h7, 2, 7, 32'h1, 32'h1, 0, 0, 7);
    @(negedge clk);
    chk("stall_b_before", out_b, 32'h1);
    tick();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h1234;
    tick();
    wb_valid = 0;
    @(negedge clk);
    chk("stall_b_refresh", out_b, 32'h1234);
    tick();
    out_ready = 1;
    repeat (2) tick();

    // Flush with both entries full and in_valid high.
    out_ready = 0;
    send(4'h8, 1, 2, 32'hC1, 32'hD1, 0, 0, 8);
    send(4'h9, 1, 2, 32'hC2, 32'hD2, 0, 0, 9);
    set_op(4'hA, 1, 2, 32'hC3, 32'hD3, 0, 0, 10);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    out_ready = 1;
    repeat (3) tick();

    // Reset mid-stream with two held ops.
    out_ready = 0;
    send(4'hB, 1, 2, 32'hE1, 32'hF1, 0, 0, 11);
    send(4'hC, 1, 2, 32'hE2, 32'hF2, 0, 0, 12);
    rst_n = 0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) tick();
    rst_n = 1;
    out_ready = 1;
    repeat (4) tick();

    // Randomized traffic with heavy index aliasing to exercise forwarding.
    for (int c = 0; c < 500; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      wb_valid   = $urandom_range(0, 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      in_opcode  = 4'($urandom);
      in_rs_a    = 5'($urandom_range(0, 7));
      in_rs_b    = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom);
      in_data_a  = $urandom;
      in_data_b  = $urandom;
      in_imm     = $urandom;
      in_use_imm = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    out_ready = 1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
